// File: rtl/rvvi_serial_pkg.sv
// Shared types for the RVVI retire serializer.
//   entry_t   : one buffered retirement (insn, pc, trap, seq)
//   SEQ_W     : width of the per-entry sequence number
//   popcount  : number of set bits in a retire-valid mask (up to MAX_RETIRE slots)
package rvvi_serial_pkg;

  localparam int unsigned ENTRY_ILEN = 32;
  localparam int unsigned ENTRY_XLEN = 64;
  localparam int unsigned SEQ_W      = 16;
  localparam int unsigned MAX_RETIRE = 4;

  typedef logic [SEQ_W-1:0] seq_t;

  typedef struct packed {
    logic [ENTRY_ILEN-1:0] insn;
    logic [ENTRY_XLEN-1:0] pc;
    logic                  trap;
    seq_t                  seq;
  } entry_t;

  function automatic logic [2:0] popcount(input logic [MAX_RETIRE-1:0] mask);
    logic [2:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_RETIRE; i++) begin
      n = n + {2'b00, mask[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/rvvi_retire_serializer_if.sv
// Bus bundle between the core RVVI trace, the serializer and the coverage sampler.
//   in_valid/in_insn/in_pc/in_trap : per-slot retire trace, slot 0 oldest
//   out_valid/out_ready            : head handshake towards the sampler
//   out_insn/out_pc/out_trap/out_seq : head entry
//   occupancy, overflow            : status
//   drop_count, max_occupancy      : only with RVVI_SERIALIZER_STATS_EN defined
// Modports: slave = serializer side, master = trace source / sampler side.
interface rvvi_retire_serializer_if #(
  parameter int unsigned ILEN   = 32,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RETIRE = 2,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [RETIRE-1:0]      in_valid;
  logic [RETIRE*ILEN-1:0] in_insn;
  logic [RETIRE*XLEN-1:0] in_pc;
  logic [RETIRE-1:0]      in_trap;
  logic                   out_valid;
  logic                   out_ready;
  logic [ILEN-1:0]        out_insn;
  logic [XLEN-1:0]        out_pc;
  logic                   out_trap;
  logic [15:0]            out_seq;
  logic [CNT_W-1:0]       occupancy;
  logic                   overflow;
`ifdef RVVI_SERIALIZER_STATS_EN
  logic [31:0]            drop_count;
  logic [CNT_W-1:0]       max_occupancy;
`endif

  modport slave (
    input  in_valid, in_insn, in_pc, in_trap, out_ready,
    output out_valid, out_insn, out_pc, out_trap, out_seq, occupancy, overflow
`ifdef RVVI_SERIALIZER_STATS_EN
    , output drop_count, max_occupancy
`endif
  );

  modport master (
    output in_valid, in_insn, in_pc, in_trap, out_ready,
    input  out_valid, out_insn, out_pc, out_trap, out_seq, occupancy, overflow
`ifdef RVVI_SERIALIZER_STATS_EN
    , input drop_count, max_occupancy
`endif
  );

endinterface

// File: rtl/rvvi_trace_fifo.sv
// Circular buffer of entry_t with RETIRE write ports and one read port.
//   wr_cnt_i  : number of write ports used this cycle; ports 0..wr_cnt_i-1 carry
//               compacted data written at wr_ptr, wr_ptr+1, ... (wraps mod DEPTH)
//   rd_en_i   : pop the head (only asserted while rd_valid_o)
//   rd_valid_o/rd_data_o : head entry; data reads as zero while empty
//   count_o   : entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module rvvi_trace_fifo
  import rvvi_serial_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned RETIRE = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       wr_cnt_i,
  input  entry_t           wr_data_i [RETIRE],
  input  logic             rd_en_i,
  output logic             rd_valid_o,
  output entry_t           rd_data_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_cnt_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
    count_d  = count_q + CNT_W'(wr_cnt_i) - CNT_W'(rd_en_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < RETIRE; k++) begin
      if (3'(k) < wr_cnt_i) begin
        mem_q[wr_ptr_q + PTR_W'(k)] <= wr_data_i[k];
      end
    end
  end

  assign count_o    = count_q;
  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/rvvi_retire_serializer.sv
// Serializes up to RETIRE retirements per cycle into a one-per-cycle ordered stream.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : rvvi_retire_serializer_if.slave (trace in, head out, status)
// Valid slots are compacted in ascending slot order; slots that do not fit are
// dropped (lowest indices win) and raise the sticky overflow flag. Each accepted
// entry takes the next 16-bit sequence number; dropped slots take none.
// Optional: RVVI_SERIALIZER_STATS_EN adds drop_count (saturating) and
// max_occupancy (high-water mark).
module rvvi_retire_serializer
  import rvvi_serial_pkg::*;
#(
  parameter int unsigned ILEN   = 32,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RETIRE = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  rvvi_retire_serializer_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [MAX_RETIRE-1:0] mask_ext;
  logic [2:0]            n_valid;
  logic [2:0]            n_accept;
  logic [2:0]            n_drop;
  logic [2:0]            rank;
  logic [2:0]            slot_rank [RETIRE];
  logic [CNT_W-1:0]      free_w;
  logic [CNT_W-1:0]      occupancy;
  logic                  head_valid;
  logic                  deq;
  entry_t                head;
  entry_t                wr_data [RETIRE];
  seq_t                  seq_q, seq_d;
  logic                  overflow_q, overflow_d;

  always_comb begin
    mask_ext = '0;
    mask_ext[RETIRE-1:0] = reset ? '0 : bus.in_valid;
    n_valid  = popcount(mask_ext);
    deq      = head_valid && bus.out_ready;
    // A same-cycle dequeue frees a slot for this cycle's enqueue.
    free_w   = CNT_W'(DEPTH) - occupancy + CNT_W'(deq);
    if (32'(n_valid) <= 32'(free_w)) n_accept = n_valid;
    else                             n_accept = 3'(free_w);
    n_drop   = n_valid - n_accept;

    // rank = position of a valid slot among the valid slots; the first n_accept
    // ranks land on write ports 0..n_accept-1, which compacts the gaps away.
    rank = '0;
    for (int unsigned i = 0; i < RETIRE; i++) begin
      slot_rank[i] = rank;
      if (mask_ext[i]) rank = rank + 3'd1;
    end

    for (int unsigned k = 0; k < RETIRE; k++) begin
      wr_data[k] = '0;
      for (int unsigned i = 0; i < RETIRE; i++) begin
        if (mask_ext[i] && (slot_rank[i] == 3'(k))) begin
          wr_data[k].insn = bus.in_insn[i*ILEN +: ILEN];
          wr_data[k].pc   = bus.in_pc[i*XLEN +: XLEN];
          wr_data[k].trap = bus.in_trap[i];
          wr_data[k].seq  = seq_q + SEQ_W'(k);
        end
      end
    end

    seq_d      = seq_q + SEQ_W'(n_accept);
    overflow_d = overflow_q | (n_drop != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
    end
  end

  rvvi_trace_fifo #(
    .DEPTH  (DEPTH),
    .RETIRE (RETIRE)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_cnt_i   (n_accept),
    .wr_data_i  (wr_data),
    .rd_en_i    (deq),
    .rd_valid_o (head_valid),
    .rd_data_o  (head),
    .count_o    (occupancy)
  );

  assign bus.out_valid = head_valid;
  assign bus.out_insn  = head.insn;
  assign bus.out_pc    = head.pc;
  assign bus.out_trap  = head.trap;
  assign bus.out_seq   = head.seq;
  assign bus.occupancy = occupancy;
  assign bus.overflow  = overflow_q;

`ifdef RVVI_SERIALIZER_STATS_EN
  logic [31:0]      drop_count_q, drop_count_d;
  logic [32:0]      drop_sum;
  logic [CNT_W-1:0] max_occ_q, max_occ_d;
  logic [CNT_W-1:0] occ_next;

  always_comb begin
    drop_sum     = {1'b0, drop_count_q} + 33'(n_drop);
    drop_count_d = drop_sum[32] ? '1 : drop_sum[31:0];
    occ_next     = occupancy + CNT_W'(n_accept) - CNT_W'(deq);
    max_occ_d    = (occ_next > max_occ_q) ? occ_next : max_occ_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_q <= '0;
      max_occ_q    <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      max_occ_q    <= max_occ_d;
    end
  end

  assign bus.drop_count    = drop_count_q;
  assign bus.max_occupancy = max_occ_q;
`endif

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
module tb_rvvi_retire_serializer;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned RETIRE = 2;
  localparam int unsigned DEPTH  = 8;

  typedef struct packed {
    logic [31:0] insn;
    logic [63:0] pc;
    logic        trap;
    logic [15:0] seq;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rvvi_retire_serializer_if #(.ILEN(ILEN), .XLEN(XLEN), .RETIRE(RETIRE), .DEPTH(DEPTH)) bus ();

  rvvi_retire_serializer #(.ILEN(ILEN), .XLEN(XLEN), .RETIRE(RETIRE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        sb[$];
  logic [15:0] m_seq;
  bit          m_ovf;
  int unsigned m_drops;
  int unsigned m_max;
  logic [15:0] last_seq;
  int          checks = 0;
  int          errors = 0;

  // One clock of stimulus: at the falling edge compare the DUT against the
  // scoreboard, then update the reference and drive the next inputs.
  task automatic drive_cycle(input logic [1:0] mask, input logic [63:0] pc0, input logic [63:0] pc1,
                             input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] trap,
                             input logic ready);
    exp_t e;
    @(negedge clk);
    checks++;
    if (bus.occupancy !== 4'(sb.size())) begin
      errors++;
      $display("FAIL occupancy: got %0d expected %0d", bus.occupancy, sb.size());
    end
    checks++;
    if (bus.out_valid !== (sb.size() != 0)) begin
      errors++;
      $display("FAIL out_valid: got %b expected %b", bus.out_valid, sb.size() != 0);
    end
    checks++;
    if (bus.overflow !== m_ovf) begin
      errors++;
      $display("FAIL overflow: got %b expected %b", bus.overflow, m_ovf);
    end
    if (sb.size() != 0) begin
      checks++;
      if ({bus.out_insn, bus.out_pc, bus.out_trap, bus.out_seq} !== sb[0]) begin
        errors++;
        $display("FAIL head: got insn=%h pc=%h trap=%b seq=%h expected insn=%h pc=%h trap=%b seq=%h",
                 bus.out_insn, bus.out_pc, bus.out_trap, bus.out_seq,
                 sb[0].insn, sb[0].pc, sb[0].trap, sb[0].seq);
      end
      if (ready) begin
        last_seq = bus.out_seq;
        void'(sb.pop_front());
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (mask[s]) begin
        if (sb.size() < DEPTH) begin
          e.insn = (s == 0) ? i0 : i1;
          e.pc   = (s == 0) ? pc0 : pc1;
          e.trap = trap[s];
          e.seq  = m_seq;
          sb.push_back(e);
          m_seq  = m_seq + 16'd1;
        end else begin
          m_ovf = 1'b1;
          m_drops++;
        end
      end
    end
    if (sb.size() > m_max) m_max = sb.size();
    bus.in_valid  = mask;
    bus.in_pc     = {pc1, pc0};
    bus.in_insn   = {i1, i0};
    bus.in_trap   = trap;
    bus.out_ready = ready;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 2'b11;
    bus.in_pc    = {64'h4, 64'h0};
    bus.in_insn  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 2'b00;
    bus.out_ready = 1'b0;
    sb.delete();
    m_seq = '0; m_ovf = 1'b0; m_drops = 0; m_max = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * DEPTH && sb.size() != 0; n++)
      drive_cycle(2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
    drive_cycle(2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 2'b11; bus.in_pc = '1; bus.in_insn = '1; bus.in_trap = 2'b11; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.occupancy, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL reset_status: got valid=%b occ=%0d ovf=%b expected 0/0/0",
               bus.out_valid, bus.occupancy, bus.overflow);
    end
    checks++;
    if ({bus.out_insn, bus.out_pc, bus.out_trap, bus.out_seq} !== '0) begin
      errors++;
      $display("FAIL reset_head: got insn=%h pc=%h trap=%b seq=%h expected all zero",
               bus.out_insn, bus.out_pc, bus.out_trap, bus.out_seq);
    end
    apply_reset();
  endtask

  task automatic test_single_retire();
    drive_cycle(2'b01, 64'h8000_0000, '0, 32'h0000_0013, '0, 2'b00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_seq, bus.occupancy, bus.out_pc} !== {1'b1, 16'h0, 4'd1, 64'h8000_0000}) begin
      errors++;
      $display("FAIL single_retire: got valid=%b seq=%h occ=%0d pc=%h expected 1/0000/1/80000000",
               bus.out_valid, bus.out_seq, bus.occupancy, bus.out_pc);
    end
    drive_cycle(2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (bus.occupancy !== 4'd0) begin
      errors++;
      $display("FAIL single_dequeue: got occ=%0d expected 0", bus.occupancy);
    end
    drive_cycle(2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic test_sparse();
    logic [15:0] exp_seq;
    exp_seq = m_seq;
    drive_cycle(2'b10, 64'h200, 64'h204, 32'hAAAA_0000, 32'h0000_0093, 2'b10, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({bus.occupancy, bus.out_pc, bus.out_seq, bus.out_trap} !== {4'd1, 64'h204, exp_seq, 1'b1}) begin
      errors++;
      $display("FAIL sparse: got occ=%0d pc=%h seq=%h trap=%b expected 1/204/%h/1",
               bus.occupancy, bus.out_pc, bus.out_seq, bus.out_trap, exp_seq);
    end
    drain();
  endtask

  task automatic test_hold_stable();
    for (int c = 0; c < 2; c++)
      drive_cycle(2'b11, 64'h300 + 64'(8*c), 64'h304 + 64'(8*c), 32'(c), 32'(c + 16), 2'b01, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(2'b00, '0, '0, '0, '0, 2'b00, 1'b0);
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.out_pc, bus.out_insn} !== {1'b1, 64'h300, 32'h0}) begin
        errors++;
        $display("FAIL hold_stable: got valid=%b pc=%h insn=%h expected 1/300/0",
                 bus.out_valid, bus.out_pc, bus.out_insn);
      end
    end
    drain();
  endtask

  task automatic test_dual_overflow();
    for (int c = 0; c < DEPTH + 2; c++) begin
      drive_cycle(2'b11, 64'h100, 64'h104, 32'(2*c), 32'(2*c + 1), 2'b00, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (bus.occupancy !== 4'((c + 2 > DEPTH) ? DEPTH : c + 2)) begin
        errors++;
        $display("FAIL dual_occupancy: cycle %0d got %0d expected %0d",
                 c, bus.occupancy, (c + 2 > DEPTH) ? DEPTH : c + 2);
      end
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_overflow: got %b expected 1", bus.overflow);
    end
  endtask

`ifdef RVVI_SERIALIZER_STATS_EN
  task automatic test_stats();
    @(posedge clk); #1;
    checks++;
    if (bus.drop_count !== 32'(m_drops) || bus.max_occupancy !== 4'(m_max)) begin
      errors++;
      $display("FAIL stats: got drops=%0d max=%0d expected %0d/%0d",
               bus.drop_count, bus.max_occupancy, m_drops, m_max);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    drain();
    for (int c = 0; c < 5; c++)
      drive_cycle(2'b01, 64'h500 + 64'(4*c), '0, 32'(c), '0, 2'b00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (bus.occupancy !== 4'd5) begin
      errors++;
      $display("FAIL midstream_fill: got occ=%0d expected 5", bus.occupancy);
    end
    apply_reset();
    #1;
    checks++;
    if ({bus.occupancy, bus.out_valid, bus.out_seq, bus.overflow} !== '0) begin
      errors++;
      $display("FAIL midstream_reset: got occ=%0d valid=%b seq=%h ovf=%b expected all zero",
               bus.occupancy, bus.out_valid, bus.out_seq, bus.overflow);
    end
    drive_cycle(2'b01, 64'h600, '0, 32'h1, '0, 2'b00, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.out_seq} !== {1'b1, 16'h0}) begin
      errors++;
      $display("FAIL midstream_seq: got valid=%b seq=%h expected 1/0000", bus.out_valid, bus.out_seq);
    end
    apply_reset();
  endtask

  task automatic test_seq_wrap();
    for (int c = 0; c < 32768; c++) begin
      drive_cycle(2'b11, 64'(4*c), 64'(4*c + 2), 32'(c), ~32'(c), 2'(c), 1'b1);
      drive_cycle(2'b00, '0, '0, '0, '0, 2'b00, 1'b1);
    end
    drive_cycle(2'b01, 64'hDEAD_0000, '0, 32'h1234_5678, '0, 2'b01, 1'b1);
    drain();
    checks++;
    if (last_seq !== 16'h0000) begin
      errors++;
      $display("FAIL seq_wrap: got last seq=%h expected 0000", last_seq);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = '0; bus.in_insn = '0; bus.in_pc = '0; bus.in_trap = '0; bus.out_ready = 1'b0;
    reset = 1'b1;
    last_seq = 16'hFFFF;
    test_reset();
    test_single_retire();
    test_sparse();
    test_hold_stable();
    test_dual_overflow();
`ifdef RVVI_SERIALIZER_STATS_EN
    test_stats();
`endif
    test_reset_midstream();
    test_seq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
